// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The slave modport is the multiplier side; the master modport is the producer/consumer side.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: classify/multiply, normalise/round, pack.
// Denormal inputs are treated as zero and no denormal results are produced.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic signed [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] EXP_MIN = {EW{1'b0}};
  localparam logic [EXP_W-1:0]     E_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     E_ZERO  = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0]     F_ZERO  = {MAN_W{1'b0}};

  typedef enum logic [1:0] {
    K_FIN  = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_t;

  logic                    stall_s;
  logic [EXP_W-1:0]        ea_s, eb_s;
  logic [MAN_W-1:0]        fa_s, fb_s;
  logic                    za_s, zb_s, ia_s, ib_s, na_s, nb_s;
  kind_t                   kind_s;
  logic signed [EW-1:0]    exp_sum_s;
  logic [PW-1:0]           prod_s;

  logic                    v1_r, sign1_r;
  kind_t                   kind1_r;
  logic signed [EW-1:0]    exp1_r;
  logic [PW-1:0]           prod1_r;

  logic                    msb_s, guard_s, sticky_s, rnd_up_s;
  logic [MAN_W-1:0]        frac_s;
  logic [MAN_W:0]          frac_rnd_s;
  logic signed [EW-1:0]    exp_n_s;

  logic                    v2_r, sign2_r;
  kind_t                   kind2_r;
  logic signed [EW-1:0]    exp2_r;
  logic [MAN_W-1:0]        frac2_r;

  logic [W-1:0]            res_s;
  logic                    ovf_s, unf_s, inv_s;

  logic                    out_valid_r;
  logic [W-1:0]            result_r;
  logic                    overflow_r, underflow_r, invalid_r;

  assign stall_s       = out_valid_r & ~bus.out_ready;
  assign bus.in_ready  = ~stall_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
  assign bus.invalid   = invalid_r;

  assign ea_s = bus.a[W-2:MAN_W];
  assign eb_s = bus.b[W-2:MAN_W];
  assign fa_s = bus.a[MAN_W-1:0];
  assign fb_s = bus.b[MAN_W-1:0];
  assign za_s = (ea_s == E_ZERO);
  assign zb_s = (eb_s == E_ZERO);
  assign ia_s = (ea_s == E_ONES) & (fa_s == F_ZERO);
  assign ib_s = (eb_s == E_ONES) & (fb_s == F_ZERO);
  assign na_s = (ea_s == E_ONES) & (fa_s != F_ZERO);
  assign nb_s = (eb_s == E_ONES) & (fb_s != F_ZERO);

  assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS;
  assign prod_s    = PW'({1'b1, fa_s}) * PW'({1'b1, fb_s});

  // Operand class with NaN / inf*0 taking precedence over inf, then zero
  always_comb begin
    kind_s = K_FIN;
    if (na_s | nb_s | (ia_s & zb_s) | (za_s & ib_s)) begin
      kind_s = K_NAN;
    end else if (ia_s | ib_s) begin
      kind_s = K_INF;
    end else if (za_s | zb_s) begin
      kind_s = K_ZERO;
    end else begin
      kind_s = K_FIN;
    end
  end

  // Normalise the product to 1.x and pick guard/sticky for round-to-nearest-even
  always_comb begin
    msb_s = prod1_r[PW-1];
    if (msb_s) begin
      frac_s   = prod1_r[PW-2:MAN_W+1];
      guard_s  = prod1_r[MAN_W];
      sticky_s = |prod1_r[MAN_W-1:0];
    end else begin
      frac_s   = prod1_r[PW-3:MAN_W];
      guard_s  = prod1_r[MAN_W-1];
      sticky_s = |prod1_r[MAN_W-2:0];
    end
    rnd_up_s   = guard_s & (sticky_s | frac_s[0]);
    // An all-ones fraction rounding up wraps to zero and carries into the exponent
    frac_rnd_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, rnd_up_s};
    exp_n_s    = exp1_r + $signed({{(EW-1){1'b0}}, msb_s})
                        + $signed({{(EW-1){1'b0}}, frac_rnd_s[MAN_W]});
  end

  // Final packing with range checks; at most one flag per result
  always_comb begin
    res_s = {W{1'b0}};
    ovf_s = 1'b0;
    unf_s = 1'b0;
    inv_s = 1'b0;
    case (kind2_r)
      K_NAN: begin
        res_s = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        inv_s = 1'b1;
      end
      K_INF:  res_s = {sign2_r, E_ONES, F_ZERO};
      K_ZERO: res_s = {sign2_r, {(W-1){1'b0}}};
      K_FIN: begin
        if (exp2_r >= EXP_MAX) begin
          res_s = {sign2_r, E_ONES, F_ZERO};
          ovf_s = 1'b1;
        end else if (exp2_r <= EXP_MIN) begin
          res_s = {sign2_r, {(W-1){1'b0}}};
          unf_s = 1'b1;
        end else begin
          res_s = {sign2_r, exp2_r[EXP_W-1:0], frac2_r};
        end
      end
      default: res_s = {W{1'b0}};
    endcase
  end

  // Pipeline registers; every stage holds while the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r        <= 1'b0;
      sign1_r     <= 1'b0;
      kind1_r     <= K_FIN;
      exp1_r      <= EXP_MIN;
      prod1_r     <= {PW{1'b0}};
      v2_r        <= 1'b0;
      sign2_r     <= 1'b0;
      kind2_r     <= K_FIN;
      exp2_r      <= EXP_MIN;
      frac2_r     <= F_ZERO;
      out_valid_r <= 1'b0;
      result_r    <= {W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      invalid_r   <= 1'b0;
    end else if (!stall_s) begin
      v1_r        <= bus.in_valid;
      sign1_r     <= bus.a[W-1] ^ bus.b[W-1];
      kind1_r     <= kind_s;
      exp1_r      <= exp_sum_s;
      prod1_r     <= prod_s;
      v2_r        <= v1_r;
      sign2_r     <= sign1_r;
      kind2_r     <= kind1_r;
      exp2_r      <= exp_n_s;
      frac2_r     <= frac_rnd_s[MAN_W-1:0];
      out_valid_r <= v2_r;
      result_r    <= v2_r ? res_s : {W{1'b0}};
      overflow_r  <= v2_r & ovf_s;
      underflow_r <= v2_r & unf_s;
      invalid_r   <= v2_r & inv_s;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23): directed vector table,
// stall/reset sequences and random traffic scored against a real-arithmetic reference.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_pipe_if bus ();
  fp_mul_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  fl;
    string       name;
  } vec_t;

  vec_t        tab [16];
  logic [34:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic        prev_stall = 1'b0;
  logic        smp_valid  = 1'b0;
  logic        smp_xfer   = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Reference: exact real product, then round-to-nearest-even on the 23-bit fraction
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic   s, xz, yz, xi, yi, xn, yn;
    int     ex, ey, e;
    real    m, sc, fl, rem;
    longint q;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'h0);
    yi = (ey == 255) && (y[22:0] == 23'h0);
    xn = (ex == 255) && (x[22:0] != 23'h0);
    yn = (ey == 255) && (y[22:0] != 23'h0);
    if (xn || yn || (xi && yz) || (xz && yi)) return {3'b001, 32'h7FC00000};
    if (xi || yi) return {3'b000, s, 8'hFF, 23'h0};
    if (xz || yz) return {3'b000, s, 31'h0};
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (1.0 + real'(y[22:0]) / 8388608.0);
    e = ex + ey - 127;
    if (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    sc  = m * 8388608.0;
    fl  = $floor(sc);
    rem = sc - fl;
    q   = longint'(fl);
    if (rem > 0.5 || (rem == 0.5 && q[0] == 1'b1)) q++;
    if (q == 64'sd16777216) begin
      q = 64'sd8388608;
      e++;
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    return {3'b000, s, 8'(e), 23'(q - 64'sd8388608)};
  endfunction

  function automatic logic [31:0] rnd_op();
    int          r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 15);
    f = 23'($urandom);
    if (r == 0) begin
      e = 8'h00;
    end else if (r == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'h0;
    end else if (r < 9) begin
      e = 8'($urandom_range(100, 154));
    end else begin
      e = 8'($urandom_range(1, 254));
    end
    return {1'($urandom), e, f};
  endfunction

  // One clock of traffic: drive at negedge, score outputs, record accepted inputs
  task automatic run_cycle(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                           input logic rdy, input logic use_tab, input logic [34:0] tv);
    logic [34:0] e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = ai;
    bus.b         = bi;
    bus.out_ready = rdy;
    #1;
    smp_valid = bus.out_valid;
    if (prev_stall) check("hold_valid", 64'(bus.out_valid), 64'd1);
    check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !rdy)));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q[0];
        check("result", 64'(bus.result), 64'(e[31:0]));
        check("flags", 64'({bus.overflow, bus.underflow, bus.invalid}), 64'(e[34:32]));
        if (rdy) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
    smp_xfer = v && bus.in_ready;
    if (smp_xfer) exp_q.push_back(use_tab ? tv : ref_mul(ai, bi));
    prev_stall = bus.out_valid && !rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa [6];
    logic [31:0] sb [6];
    logic [31:0] ra, rb;
    int lat, idx, acc0;

    tab[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, "mul_1p5x2"};
    tab[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, "rne_drop"};
    tab[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, "overflow"};
    tab[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010, "underflow"};
    tab[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, "inf_x_zero"};
    tab[5]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, "neg_zero"};
    tab[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, "neg_inf"};
    tab[7]  = '{32'hFFA00000, 32'h3F800000, 32'h7FC00000, 3'b001, "nan_sign"};
    tab[8]  = '{32'h00000001, 32'hBF800000, 32'h80000000, 3'b000, "denorm_flush"};
    tab[9]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, "tie_odd_up"};
    tab[10] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, "tie_even_hold"};
    tab[11] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, "norm_shift"};
    tab[12] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, "ovf_edge"};
    tab[13] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, "max_finite"};
    tab[14] = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, "unf_edge"};
    tab[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, "min_normal"};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags", 64'({bus.overflow, bus.underflow, bus.invalid}), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, one at a time, with latency measured from the presenting cycle
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b1, tab[i].a, tab[i].b, 1'b1, 1'b1, {tab[i].fl, tab[i].res});
      lat = 0;
      for (int k = 1; k <= 3; k++) begin
        run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 35'h0);
        if (smp_valid && lat == 0) lat = k;
      end
      check({"latency_", tab[i].name}, 64'(lat), 64'd3);
    end

    // Six back-to-back ops with out_ready low for four cycles mid-stream
    for (int i = 0; i < 6; i++) begin
      sa[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      sb[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    idx  = 0;
    acc0 = n_acc;
    for (int c = 0; c < 20; c++) begin
      if (idx < 6) run_cycle(1'b1, sa[idx], sb[idx], !(c >= 3 && c < 7), 1'b0, 35'h0);
      else         run_cycle(1'b0, 32'h0, 32'h0, !(c >= 3 && c < 7), 1'b0, 35'h0);
      if (smp_xfer) idx++;
    end
    check("stream_count", 64'(n_acc - acc0), 64'd6);
    check("stream_empty", 64'(exp_q.size()), 64'd0);

    // Reset with operations in flight and the oldest one parked at the output
    for (int i = 0; i < 3; i++) run_cycle(1'b1, sa[i], sb[i], 1'b1, 1'b0, 35'h0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_flush_valid", 64'(bus.out_valid), 64'd0);
    check("reset_flush_result", 64'(bus.result), 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    for (int c = 0; c < 8; c++) run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 35'h0);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      ra = rnd_op();
      rb = rnd_op();
      run_cycle($urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 9) < 7, 1'b0, 35'h0);
    end
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 35'h0);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
